// File: rtl/fft_iter_if.sv
// Streaming handshake bundle for the iterative FFT: sample input side,
// bin output side and the busy flag. The master drives samples and
// out_ready, and the slave (the FFT core) answers.
interface fft_iter_if #(
  parameter int LOG2N = 3,
  parameter int W     = 16
);
  logic                    in_valid;
  logic                    in_ready;
  logic signed [W-1:0]     in_re;
  logic signed [W-1:0]     in_im;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [W-1:0]     out_re;
  logic signed [W-1:0]     out_im;
  logic        [LOG2N-1:0] out_idx;
  logic                    out_last;
  logic                    busy;

  modport master (
    output in_valid, in_re, in_im, out_ready,
    input  in_ready, out_valid, out_re, out_im, out_idx, out_last, busy
  );

  modport slave (
    input  in_valid, in_re, in_im, out_ready,
    output in_ready, out_valid, out_re, out_im, out_idx, out_last, busy
  );
endinterface

// File: rtl/fft_iter.sv
// Iterative radix-2 decimation-in-time FFT with one in-place complex RAM.
// Samples are loaded in bit-reversed order, LOG2N stages of N/2 butterflies
// run one per cycle, and bins are unloaded in natural order.
// The twiddle rounding assumes FRAC >= 1.
module fft_iter #(
  parameter int LOG2N = 3,
  parameter int W     = 16,
  parameter int FRAC  = 8,
  parameter int SCALE = 0
) (
  input  logic      clk,
  input  logic      rst,
  fft_iter_if.slave io_bus
);
  localparam int  N      = 1 << LOG2N;
  localparam int  HALF   = N / 2;
  localparam int  BW     = LOG2N - 1;
  localparam int  TW     = FRAC + 2;
  localparam int  PW     = W + TW + 2;
  localparam int  SBW    = $clog2(LOG2N);
  localparam real TWO_PI = 6.283185307179586;

  localparam logic signed [PW-1:0] RND_T  = PW'(1) <<< (FRAC - 1);
  localparam logic signed [PW-1:0] SAT_HI = PW'((64'sd1 <<< (W - 1)) - 64'sd1);
  localparam logic signed [PW-1:0] SAT_LO = -SAT_HI - PW'(1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CALC, S_UNLOAD} state_t;

  state_t              r_state, w_nextState;
  logic [LOG2N-1:0]    r_inCnt, r_outIdx;
  logic [SBW-1:0]      r_stage;
  logic [BW-1:0]       r_bfly;
  logic signed [W-1:0] r_memRe [N];
  logic signed [W-1:0] r_memIm [N];
  logic signed [TW-1:0] w_twRe [HALF];
  logic signed [TW-1:0] w_twIm [HALF];

  logic                w_inReady, w_outValid, w_accept, w_outFire;
  logic                w_stageEnd, w_lastBfly;
  logic [LOG2N-1:0]    w_loadAddr, w_jExt, w_h, w_addrA, w_addrB, w_twFull;
  logic [BW-1:0]       w_twIdx;
  logic signed [PW-1:0] w_x1Re, w_x1Im, w_x2Re, w_x2Im, w_wRe, w_wIm;
  logic signed [PW-1:0] w_pRe, w_pIm, w_tRe, w_tIm;
  logic signed [PW-1:0] w_s1Re, w_s1Im, w_s2Re, w_s2Im;
  logic signed [W-1:0]  w_y1Re, w_y1Im, w_y2Re, w_y2Im;

  function automatic int roundReal(input real x);
    if (x >= 0.0) return $rtoi(x + 0.5);
    else          return -$rtoi(-x + 0.5);
  endfunction

  function automatic logic [LOG2N-1:0] bitRev(input logic [LOG2N-1:0] v);
    logic [LOG2N-1:0] res;
    for (int i = 0; i < LOG2N; i++) res[i] = v[LOG2N-1-i];
    return res;
  endfunction

  function automatic logic signed [W-1:0] satW(input logic signed [PW-1:0] v);
    if (v > SAT_HI)      return SAT_HI[W-1:0];
    else if (v < SAT_LO) return SAT_LO[W-1:0];
    else                 return v[W-1:0];
  endfunction

  // Twiddle ROM W^k = exp(-j*2*pi*k/N), fixed at elaboration
  for (genvar k = 0; k < HALF; k++) begin : g_tw
    localparam int TW_RE = roundReal($cos(TWO_PI * real'(k) / real'(N)) * real'(1 << FRAC));
    localparam int TW_IM = -roundReal($sin(TWO_PI * real'(k) / real'(N)) * real'(1 << FRAC));
    assign w_twRe[k] = TW_RE[TW-1:0];
    assign w_twIm[k] = TW_IM[TW-1:0];
  end

  assign w_accept   = io_bus.in_valid & w_inReady;
  assign w_outFire  = w_outValid & io_bus.out_ready;
  assign w_loadAddr = bitRev(r_inCnt);
  assign w_stageEnd = (r_bfly == '1);
  assign w_lastBfly = (r_state == S_CALC) && w_stageEnd && (r_stage == SBW'(LOG2N - 1));

  assign io_bus.in_ready  = w_inReady;
  assign io_bus.out_valid = w_outValid;
  assign io_bus.out_idx   = w_outValid ? r_outIdx : '0;
  assign io_bus.out_last  = w_outValid && (r_outIdx == '1);
  assign io_bus.out_re    = w_outValid ? r_memRe[r_outIdx] : '0;
  assign io_bus.out_im    = w_outValid ? r_memIm[r_outIdx] : '0;
  assign io_bus.busy      = rst && (r_state != S_IDLE);

  // State register, forced to IDLE by reset from anywhere in the frame
  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_nextState;
  end

  // Next-state and handshake outputs; reset masks both ready and valid
  always_comb begin
    w_nextState = r_state;
    w_inReady   = 1'b0;
    w_outValid  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_inReady = 1'b1;
        if (io_bus.in_valid) w_nextState = S_LOAD;
      end
      S_LOAD: begin
        w_inReady = 1'b1;
        if (io_bus.in_valid && (r_inCnt == '1)) w_nextState = S_CALC;
      end
      S_CALC: begin
        if (w_lastBfly) w_nextState = S_UNLOAD;
      end
      S_UNLOAD: begin
        w_outValid = 1'b1;
        if (io_bus.out_ready && (r_outIdx == '1)) w_nextState = S_IDLE;
      end
      default: w_nextState = S_IDLE;
    endcase
    if (!rst) begin
      w_inReady  = 1'b0;
      w_outValid = 1'b0;
    end
  end

  // Sample, stage, butterfly and output-bin counters
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_inCnt  <= '0;
      r_stage  <= '0;
      r_bfly   <= '0;
      r_outIdx <= '0;
    end else begin
      if (w_accept) r_inCnt <= r_inCnt + LOG2N'(1);
      if (r_state == S_CALC) begin
        r_bfly <= r_bfly + BW'(1);
        if (w_stageEnd) r_stage <= w_lastBfly ? '0 : r_stage + SBW'(1);
      end
      if (w_outFire) r_outIdx <= r_outIdx + LOG2N'(1);
    end
  end

  // Butterfly addressing: a = (j/h)*2h + (j mod h), partner a+h, twiddle (j mod h)*N/(2h)
  always_comb begin
    w_jExt   = {1'b0, r_bfly};
    w_h      = LOG2N'(1) << r_stage;
    w_addrA  = (((w_jExt >> r_stage) << r_stage) << 1) | (w_jExt & (w_h - LOG2N'(1)));
    w_addrB  = w_addrA | w_h;
    w_twFull = (w_jExt & (w_h - LOG2N'(1))) << (SBW'(LOG2N - 1) - r_stage);
    w_twIdx  = w_twFull[BW-1:0];
  end

  // Complex butterfly; the sums are kept wide enough that nothing wraps before saturation
  always_comb begin
    w_x1Re = PW'(r_memRe[w_addrA]);
    w_x1Im = PW'(r_memIm[w_addrA]);
    w_x2Re = PW'(r_memRe[w_addrB]);
    w_x2Im = PW'(r_memIm[w_addrB]);
    w_wRe  = PW'(w_twRe[w_twIdx]);
    w_wIm  = PW'(w_twIm[w_twIdx]);
    w_pRe  = w_x2Re * w_wRe - w_x2Im * w_wIm;
    w_pIm  = w_x2Re * w_wIm + w_x2Im * w_wRe;
    w_tRe  = (w_pRe + RND_T) >>> FRAC;
    w_tIm  = (w_pIm + RND_T) >>> FRAC;
    w_s1Re = w_x1Re + w_tRe;
    w_s1Im = w_x1Im + w_tIm;
    w_s2Re = w_x1Re - w_tRe;
    w_s2Im = w_x1Im - w_tIm;
    if (SCALE == 1) begin
      w_s1Re = (w_s1Re + PW'(1)) >>> 1;
      w_s1Im = (w_s1Im + PW'(1)) >>> 1;
      w_s2Re = (w_s2Re + PW'(1)) >>> 1;
      w_s2Im = (w_s2Im + PW'(1)) >>> 1;
    end
    w_y1Re = satW(w_s1Re);
    w_y1Im = satW(w_s1Im);
    w_y2Re = satW(w_s2Re);
    w_y2Im = satW(w_s2Im);
  end

  // In-place RAM: bit-reversed sample writes while loading, butterfly write-back while computing
  always_ff @(posedge clk) begin
    if (rst) begin
      if (w_accept) begin
        r_memRe[w_loadAddr] <= io_bus.in_re;
        r_memIm[w_loadAddr] <= io_bus.in_im;
      end else if (r_state == S_CALC) begin
        r_memRe[w_addrA] <= w_y1Re;
        r_memIm[w_addrA] <= w_y1Im;
        r_memRe[w_addrB] <= w_y2Re;
        r_memIm[w_addrB] <= w_y2Im;
      end
    end
  end
endmodule

// File: doc/fft_iter.md
FFT_ITER -- requirements
Module: fft_iter

Interface
REQ-001 Parameter LOG2N, default 3, SHALL set the transform size N = 2^LOG2N; legal range 3..6.
REQ-002 Parameter W, default 16, SHALL set the signed width of each real and imaginary sample.
REQ-003 Parameter FRAC, default 8, SHALL set twiddle fractional bits; twiddle width is FRAC+2, signed, and 1.0 = 2^FRAC.
REQ-004 Parameter SCALE, default 0, SHALL select per-stage halving when set to 1.
REQ-005 clk  in  1  clock; all logic SHALL be rising-edge.
REQ-006 rst  in  1  reset; synchronous, active-low.
REQ-007 in_valid  in  1  input sample valid.
REQ-008 in_ready  out  1  block accepts an input sample.
REQ-009 in_re, in_im  in  W each  signed input sample, time order n = 0..N-1.
REQ-010 out_valid  out  1  output bin valid.
REQ-011 out_ready  in  1  downstream accepts the output bin.
REQ-012 out_re, out_im  out  W each  signed output bin, natural order k = 0..N-1.
REQ-013 out_idx  out  LOG2N  bin index of the current output.
REQ-014 out_last  out  1  high with bin N-1.
REQ-015 busy  out  1  high in every state except IDLE.

Function
REQ-016 FSM states SHALL be IDLE, LOAD, CALC and UNLOAD, with a single in-place complex RAM of N entries.
REQ-017 IDLE: in_ready=1; the first accepted sample (in_valid & in_ready) SHALL be stored and the FSM SHALL enter LOAD.
REQ-018 LOAD: in_ready=1; sample n SHALL be written to address bitrev(n); acceptance of sample N-1 SHALL move the FSM to CALC on the next cycle.
REQ-019 in_ready SHALL be 0 in CALC and UNLOAD; in_valid in those states SHALL be ignored.
REQ-020 CALC SHALL execute radix-2 DIT stages s = 0..LOG2N-1, one butterfly per cycle, N/2 butterflies per stage, for exactly LOG2N*N/2 cycles.
REQ-021 Each butterfly SHALL read and write RAM in the same cycle, with no stall between stages.
REQ-022 Stage s, butterfly j SHALL pair addresses a and a+h, where h = 2^s, a = (j/h)*2h + (j mod h), and twiddle index = (j mod h)*(N/(2h)).
REQ-023 The twiddle ROM SHALL hold N/2 entries fixed at elaboration: Wr = round(cos(2πk/N)*2^FRAC), Wi = -round(sin(2πk/N)*2^FRAC).
REQ-024 Product t = x2*W SHALL be computed at full width, then rounded half-up and arithmetic-shifted right by FRAC.
REQ-025 The butterfly SHALL produce y1 = x1+t and y2 = x1-t at W+1 bits.
REQ-026 With SCALE=1, y1 and y2 SHALL then be rounded half-up and shifted right 1.
REQ-027 Each result SHALL be saturated to [-2^(W-1), 2^(W-1)-1] before write-back.
REQ-028 After the last butterfly the FSM SHALL enter UNLOAD with out_idx=0.
REQ-029 UNLOAD: out_valid=1, and out_re/out_im SHALL equal RAM[out_idx].
REQ-030 On out_valid & out_ready, out_idx SHALL increment; out_re, out_im and out_idx SHALL be held stable while out_ready=0.
REQ-031 The handshake on bin N-1 (out_last=1) SHALL return the FSM to IDLE; in_ready SHALL rise the next cycle.
REQ-032 Minimum frame period SHALL be N + LOG2N*N/2 + N cycles plus one transition cycle, with no input/output overlap.

Reset
REQ-033 rst=0 at a clock edge SHALL force IDLE from any state, including mid-LOAD, mid-CALC and mid-UNLOAD, and discard the partial frame.
REQ-034 During reset: in_ready=0, out_valid=0, out_last=0, busy=0, out_idx=0, out_re=0, out_im=0.
REQ-035 RAM contents need not be cleared, but SHALL never appear on the outputs before a full new frame is computed.

Verification
REQ-036 N=8, SCALE=0, impulse x0=1000+0j, others 0 -> all 8 bins 1000+0j, out_last on bin 7.
REQ-037 N=8, SCALE=0, all x=1000+0j -> X0=8000+0j, X1..X7=0 (±1 LSB); same input with SCALE=1 -> X0=1000+0j.
REQ-038 N=8, x[n]=1000*cos(πn/2), i.e. 1000,0,-1000,0,... -> X2=X6=4000+0j, other bins 0 (±2 LSB).
REQ-039 N=8, SCALE=0, all x=32767 -> X0 saturates to 32767, no wrap to negative.
REQ-040 out_ready toggled 1/0 every cycle during UNLOAD -> bins unchanged and in order, no drops or duplicates.
REQ-041 rst pulsed low for 1 cycle at CALC cycle 5, then a new impulse frame is sent -> busy=0 after the reset edge, and the next frame output is correct.
REQ-042 LOG2N=6 random frame -> matches a bit-accurate reference model, and CALC lasts exactly 192 cycles.
